// File: rtl/teclado_scan_if.sv
// Keypad matrix bundle: row lines in, column strobes and key events out.
// The scan driver takes the master side; the keypad/consumer takes the slave side.
interface teclado_scan_if;
  logic [2:0] linha_in;
  logic [2:0] coluna_out;
  logic [3:0] key_out;
  logic       key_valid_out;
  logic       key_held_out;

  modport master (
    input  linha_in,
    output coluna_out,
    output key_out,
    output key_valid_out,
    output key_held_out
  );

  modport slave (
    output linha_in,
    input  coluna_out,
    input  key_out,
    input  key_valid_out,
    input  key_held_out
  );
endinterface

// File: rtl/teclado_scan.sv
// 3x3 keypad scanner: one-hot column strobes, synchronized/debounced rows, key code 1..9.
// Optional TECLADO_AUTOREPEAT_EN adds periodic key_valid_out pulses while a key is held.
module teclado_scan #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
`ifdef TECLADO_AUTOREPEAT_EN
  ,
  parameter int REPEAT_SCANS   = 8
`endif
) (
  input  logic           clock_in,
  input  logic           reset_in,
  teclado_scan_if.master kp
);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_LIM  = 4'(DEBOUNCE_SCANS);

`ifdef TECLADO_AUTOREPEAT_EN
  localparam int              REP_W    = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_LIM  = REP_W'(REPEAT_SCANS);

  logic [REP_W-1:0] rep_cnt_reg;
`else
  // Single pulse per press: no repeat counter exists in this build.
`endif

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [2:0]       sync1_reg;
  logic [2:0]       sync2_reg;
  logic [2:0]       coluna_reg;
  logic [2:0]       row_reg;
  logic [3:0]       cand_reg;
  logic [3:0]       deb_cnt_reg;
  logic [3:0]       rel_cnt_reg;
  logic [3:0]       key_reg;
  logic             valid_reg;
  logic             held_reg;

  logic             tick;
  logic [2:0]       sample;
  logic [2:0]       row_hit;
  logic             single;
  logic [1:0]       col_idx;
  logic [1:0]       row_idx;
  logic [3:0]       code_now;
  logic             released;
  logic             release_done;

  assign tick   = (div_reg == DIV_LAST);
  assign sample = sync2_reg;

  // A row pattern is a usable key only when exactly one row line is high.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row_hit
      localparam logic [2:0] ONEHOT = 3'(1 << gi);
      assign row_hit[gi] = (sample == ONEHOT);
    end
  endgenerate

  assign single   = |row_hit;
  assign col_idx  = {coluna_reg[2], coluna_reg[1]};
  assign row_idx  = {sample[2], sample[1]};
  assign code_now = ({2'b00, col_idx} * 4'd3) + {2'b00, row_idx} + 4'd1;

  // Only the latched row matters while held; other rows of this column are ignored.
  assign released     = ~|(sample & row_reg);
  assign release_done = released && ((rel_cnt_reg + 4'd1) == DEB_LIM);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      div_reg   <= '0;
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      div_reg   <= tick ? '0 : div_reg + DIV_W'(1);
      sync1_reg <= kp.linha_in;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_reg   <= SCAN;
      coluna_reg  <= 3'b001;
      row_reg     <= '0;
      cand_reg    <= '0;
      deb_cnt_reg <= '0;
      rel_cnt_reg <= '0;
      key_reg     <= '0;
      valid_reg   <= 1'b0;
      held_reg    <= 1'b0;
`ifdef TECLADO_AUTOREPEAT_EN
      rep_cnt_reg <= '0;
`endif
    end else begin
      valid_reg <= 1'b0;
      if (tick) begin
        unique case (state_reg)
          SCAN: begin
            if (single) begin
              row_reg     <= sample;
              cand_reg    <= code_now;
              deb_cnt_reg <= 4'd1;
              rel_cnt_reg <= '0;
`ifdef TECLADO_AUTOREPEAT_EN
              rep_cnt_reg <= '0;
`endif
              if (DEB_LIM == 4'd1) begin
                key_reg   <= code_now;
                valid_reg <= 1'b1;
                held_reg  <= 1'b1;
                state_reg <= HELD;
              end else begin
                state_reg <= DEBOUNCE;
              end
            end else begin
              coluna_reg <= {coluna_reg[1:0], coluna_reg[2]};
            end
          end

          DEBOUNCE: begin
            if (sample == row_reg) begin
              deb_cnt_reg <= deb_cnt_reg + 4'd1;
              if ((deb_cnt_reg + 4'd1) == DEB_LIM) begin
                key_reg   <= cand_reg;
                valid_reg <= 1'b1;
                held_reg  <= 1'b1;
                state_reg <= HELD;
              end
            end else begin
              // Column stays put here; the next tick in SCAN resumes rotation.
              deb_cnt_reg <= '0;
              state_reg   <= SCAN;
            end
          end

          HELD: begin
            if (release_done) begin
              held_reg    <= 1'b0;
              rel_cnt_reg <= '0;
              state_reg   <= SCAN;
            end else if (released) begin
              rel_cnt_reg <= rel_cnt_reg + 4'd1;
            end else begin
              rel_cnt_reg <= '0;
            end
`ifdef TECLADO_AUTOREPEAT_EN
            if (release_done) begin
              rep_cnt_reg <= '0;
            end else if ((rep_cnt_reg + REP_W'(1)) == REP_LIM) begin
              rep_cnt_reg <= '0;
              valid_reg   <= 1'b1;
            end else begin
              rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
            end
`endif
          end

          default: state_reg <= SCAN;
        endcase
      end
    end
  end

  assign kp.coluna_out    = coluna_reg;
  assign kp.key_out       = key_reg;
  assign kp.key_valid_out = valid_reg;
  assign kp.key_held_out  = held_reg;

endmodule

// File: tb/tb_teclado_scan.sv
// Self-checking bench for teclado_scan: keypad matrix model plus a key-event scoreboard.
// Expected key codes are queued when a press is applied and checked on each valid pulse.
module tb_teclado_scan;

  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  teclado_scan_if kp ();

  teclado_scan dut (
    .clock_in (clk),
    .reset_in (srst),
    .kp       (kp)
  );

  // Matrix model: a pressed key drives its row only while its column is strobed.
  logic       raw_mode  = 1'b0;
  logic [2:0] raw_linha = 3'b000;
  logic       press_on  = 1'b0;
  logic [1:0] press_col = 2'd0;
  logic [1:0] press_row = 2'd0;

  assign kp.linha_in = raw_mode ? raw_linha :
                       ((press_on && kp.coluna_out[press_col]) ? 3'(1 << press_row) : 3'b000);

  int         pass_cnt   = 0;
  int         total_cnt  = 0;
  int         valid_seen = 0;
  bit         prev_valid = 1'b0;
  logic [3:0] sb_q[$];

`ifdef TECLADO_AUTOREPEAT_EN
  localparam int HOLD_PULSES = 13;
`else
  localparam int HOLD_PULSES = 1;
`endif

  // Scoreboard monitor: every pulse must match a queued expectation.
  initial begin
    logic [3:0] exp_key;
    forever begin
      @(negedge clk);
      if (!srst && kp.key_valid_out) begin
        valid_seen++;
        total_cnt++;
        if (prev_valid) $display("FAIL valid_back_to_back: key_valid_out high in two consecutive cycles");
        else pass_cnt++;
        total_cnt++;
        if (sb_q.size() == 0) begin
          $display("FAIL unexpected_pulse: key_out=%0d with no key expected", kp.key_out);
        end else begin
          exp_key = sb_q.pop_front();
          if (kp.key_out !== exp_key)
            $display("FAIL key_code: key_out=%0d expected %0d", kp.key_out, exp_key);
          else begin
            pass_cnt++;
            $display("pulse key_out=%0d ok at %0t", kp.key_out, $time);
          end
        end
        total_cnt++;
        if (kp.key_held_out !== 1'b1) $display("FAIL held_with_pulse: key_held_out=%b expected 1", kp.key_held_out);
        else pass_cnt++;
      end
      prev_valid = !srst && kp.key_valid_out;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    srst = 1'b1;
    raw_mode = 1'b0;
    raw_linha = 3'b000;
    press_on = 1'b0;
    step(2);
    srst = 1'b0;
  endtask

  task automatic wait_col(input logic [2:0] c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 48; i++) begin
      step(1);
      if (kp.coluna_out === c) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pulse(input int max_cyc, output int cyc, output bit ok);
    int start;
    start = valid_seen;
    ok = 1'b0;
    cyc = 0;
    while (cyc < max_cyc) begin
      step(1);
      cyc++;
      if (valid_seen != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int start;
    srst = 1'b1;
    step(2);
    total_cnt++;
    if (kp.coluna_out !== 3'b001) $display("FAIL reset_coluna: got %b expected 001", kp.coluna_out); else pass_cnt++;
    total_cnt++;
    if (kp.key_out !== 4'd0) $display("FAIL reset_key: got %0d expected 0", kp.key_out); else pass_cnt++;
    total_cnt++;
    if (kp.key_valid_out !== 1'b0 || kp.key_held_out !== 1'b0)
      $display("FAIL reset_flags: valid=%b held=%b expected 0 0", kp.key_valid_out, kp.key_held_out);
    else pass_cnt++;
    start = valid_seen;
    srst = 1'b0;
    step(3);
    total_cnt++;
    if (kp.coluna_out !== 3'b001) $display("FAIL rot_hold: got %b expected 001 after 3 cycles", kp.coluna_out); else pass_cnt++;
    step(1);
    total_cnt++;
    if (kp.coluna_out !== 3'b010) $display("FAIL rot_4: got %b expected 010", kp.coluna_out); else pass_cnt++;
    step(4);
    total_cnt++;
    if (kp.coluna_out !== 3'b100) $display("FAIL rot_8: got %b expected 100", kp.coluna_out); else pass_cnt++;
    step(4);
    total_cnt++;
    if (kp.coluna_out !== 3'b001) $display("FAIL rot_12: got %b expected 001", kp.coluna_out); else pass_cnt++;
    step(40);
    total_cnt++;
    if (valid_seen != start) $display("FAIL idle_pulse: %0d pulses expected 0", valid_seen - start); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_press_release();
    bit ok;
    int cyc;
    do_reset();
    wait_col(3'b010, ok);
    total_cnt++;
    if (!ok) $display("FAIL press_col_wait: coluna=%b never reached 010", kp.coluna_out); else pass_cnt++;
    press_col = 2'd1;
    press_row = 2'd2;
    press_on = 1'b1;
    sb_q.push_back(4'd6);
    wait_pulse(40, cyc, ok);
    total_cnt++;
    if (!ok || cyc > 27) $display("FAIL press_latency: seen=%b cycles=%0d expected pulse within 27", ok, cyc); else pass_cnt++;
    step(1);
    total_cnt++;
    if (kp.key_valid_out !== 1'b0) $display("FAIL pulse_width: valid=%b expected 0", kp.key_valid_out); else pass_cnt++;
    step(20);
    total_cnt++;
    if (kp.coluna_out !== 3'b010 || kp.key_held_out !== 1'b1 || kp.key_out !== 4'd6)
      $display("FAIL held_state: coluna=%b held=%b key=%0d expected 010 1 6", kp.coluna_out, kp.key_held_out, kp.key_out);
    else pass_cnt++;
    press_on = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (kp.key_held_out === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (!ok) $display("FAIL release_time: held=%b still high after 15 cycles", kp.key_held_out); else pass_cnt++;
    total_cnt++;
    if (kp.key_out !== 4'd6) $display("FAIL key_kept: got %0d expected 6", kp.key_out); else pass_cnt++;
    wait_col(3'b100, ok);
    total_cnt++;
    if (!ok) $display("FAIL rotation_resume: coluna=%b never reached 100", kp.coluna_out); else pass_cnt++;
    $display("test_press_release done");
  endtask

  task automatic test_bounce();
    int start;
    do_reset();
    start = valid_seen;
    raw_mode = 1'b1;
    raw_linha = 3'b001;
    step(9);
    raw_linha = 3'b000;
    step(4);
    total_cnt++;
    if (kp.coluna_out !== 3'b001) $display("FAIL bounce_frozen: got %b expected 001", kp.coluna_out); else pass_cnt++;
    step(3);
    total_cnt++;
    if (kp.coluna_out !== 3'b010) $display("FAIL bounce_resume: got %b expected 010", kp.coluna_out); else pass_cnt++;
    step(8);
    total_cnt++;
    if (valid_seen != start || kp.key_out !== 4'd0 || kp.key_held_out !== 1'b0)
      $display("FAIL bounce_accept: pulses=%0d key=%0d held=%b expected 0 0 0", valid_seen - start, kp.key_out, kp.key_held_out);
    else pass_cnt++;
    raw_mode = 1'b0;
    $display("test_bounce done");
  endtask

  task automatic test_invalid();
    bit ok;
    int cyc;
    do_reset();
    wait_col(3'b100, ok);
    total_cnt++;
    if (!ok) $display("FAIL invalid_col_wait: coluna=%b never reached 100", kp.coluna_out); else pass_cnt++;
    raw_mode = 1'b1;
    raw_linha = 3'b011;
    step(5);
    total_cnt++;
    if (kp.coluna_out !== 3'b001) $display("FAIL invalid_no_freeze: got %b expected 001", kp.coluna_out); else pass_cnt++;
    raw_mode = 1'b0;
    press_col = 2'd2;
    press_row = 2'd1;
    press_on = 1'b1;
    sb_q.push_back(4'd8);
    wait_pulse(60, cyc, ok);
    total_cnt++;
    if (!ok) $display("FAIL key8_pulse: no pulse within 60 cycles"); else pass_cnt++;
    step(1);
    total_cnt++;
    if (kp.coluna_out !== 3'b100 || kp.key_out !== 4'd8)
      $display("FAIL key8_state: coluna=%b key=%0d expected 100 8", kp.coluna_out, kp.key_out);
    else pass_cnt++;
    press_on = 1'b0;
    step(20);
    $display("test_invalid done");
  endtask

  task automatic test_hold();
    bit ok;
    int cyc;
    int start;
    do_reset();
    start = valid_seen;
    for (int i = 0; i < HOLD_PULSES; i++) sb_q.push_back(4'd1);
    press_col = 2'd0;
    press_row = 2'd0;
    press_on = 1'b1;
    wait_pulse(60, cyc, ok);
    total_cnt++;
    if (!ok) $display("FAIL hold_first_pulse: no pulse within 60 cycles"); else pass_cnt++;
    step(380);
    press_on = 1'b0;
    step(30);
    total_cnt++;
    if (valid_seen - start != HOLD_PULSES)
      $display("FAIL hold_pulse_count: got %0d expected %0d", valid_seen - start, HOLD_PULSES);
    else pass_cnt++;
    total_cnt++;
    if (kp.key_held_out !== 1'b0 || kp.key_out !== 4'd1)
      $display("FAIL hold_release: held=%b key=%0d expected 0 1", kp.key_held_out, kp.key_out);
    else pass_cnt++;
    $display("test_hold done");
  endtask

  task automatic test_reset_held();
    bit ok;
    int cyc;
    do_reset();
    press_col = 2'd2;
    press_row = 2'd2;
    press_on = 1'b1;
    sb_q.push_back(4'd9);
    wait_pulse(60, cyc, ok);
    total_cnt++;
    if (!ok) $display("FAIL key9_pulse: no pulse within 60 cycles"); else pass_cnt++;
    step(5);
    total_cnt++;
    if (kp.key_held_out !== 1'b1) $display("FAIL key9_held: got %b expected 1", kp.key_held_out); else pass_cnt++;
    srst = 1'b1;
    step(1);
    total_cnt++;
    if (kp.coluna_out !== 3'b001 || kp.key_out !== 4'd0 || kp.key_held_out !== 1'b0 || kp.key_valid_out !== 1'b0)
      $display("FAIL midreset: coluna=%b key=%0d held=%b valid=%b expected 001 0 0 0",
               kp.coluna_out, kp.key_out, kp.key_held_out, kp.key_valid_out);
    else pass_cnt++;
    srst = 1'b0;
    sb_q.push_back(4'd9);
    wait_pulse(80, cyc, ok);
    total_cnt++;
    if (!ok) $display("FAIL key9_redetect: no pulse within 80 cycles"); else pass_cnt++;
    press_on = 1'b0;
    step(20);
    $display("test_reset_held done");
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_invalid();
    test_hold();
    test_reset_held();
    total_cnt++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain: %0d expected keys never seen", sb_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
